address_generate_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational effective-address generator in the decode unit.
- Computes the effective address (EA) as base + index*scale + displacement, with 16/32-bit address-size wrap.
- Resolves the segment from an override or the default, adds the segment base from the descriptor cache, and optionally checks the segment limit.
- Two-stage pipeline with valid/ready handshake; sits between instruction decode and the bus/paging interface.

---
 rtl/address_generate_pipe.sv | 127 ++++++++++++
 tb/tb_address_generate_pipe.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/address_generate_pipe.sv
// address_generate_pipe: two-stage effective/linear address generator.
// Stage 1 forms the effective address (base + index<<scale + disp, with
// optional 16-bit wrap) and resolves the segment; stage 2 adds the segment
// base and raises a fault for invalid segments.
// Optional macro AGU_LIMIT_CHECK_EN adds a segment limit check in stage 2.
`timescale 1ns/1ps
module address_generate_pipe #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SEG    = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_address_size,
  input  logic [ADDR_WIDTH-1:0]         in_base,
  input  logic [ADDR_WIDTH-1:0]         in_index,
  input  logic [1:0]                    in_scale,
  input  logic [ADDR_WIDTH-1:0]         in_displacement,
  input  logic [2:0]                    in_seg_default,
  input  logic                          in_seg_override_valid,
  input  logic [2:0]                    in_seg_override,
  input  logic [NUM_SEG*ADDR_WIDTH-1:0] seg_base,
  input  logic [NUM_SEG*ADDR_WIDTH-1:0] seg_limit,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_linear,
  output logic [ADDR_WIDTH-1:0]         out_offset,
  output logic [2:0]                    out_seg,
  output logic                          out_fault
);

  localparam logic [ADDR_WIDTH-1:0] MASK16 = ADDR_WIDTH'(17'h0FFFF);

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_ea;
  logic [2:0]            s1_seg;

  logic                  s2_advance;
  logic [ADDR_WIDTH-1:0] index_scaled;
  logic [ADDR_WIDTH-1:0] ea_sum;
  logic [ADDR_WIDTH-1:0] ea_next;
  logic [2:0]            seg_next;

  logic [ADDR_WIDTH-1:0] sel_base;
  logic                  seg_bad;
  logic                  limit_fault;
  logic [ADDR_WIDTH-1:0] linear_next;

  // Output stage can take new data when empty or being consumed now.
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  // Stage 1 arithmetic; carries past ADDR_WIDTH fall off naturally.
  assign index_scaled = in_index << in_scale;
  assign ea_sum       = in_base + index_scaled + in_displacement;
  assign ea_next      = in_address_size ? ea_sum : (ea_sum & MASK16);
  assign seg_next     = in_seg_override_valid ? in_seg_override : in_seg_default;

  // Stage 1 register: loads whenever the input side is ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ea    <= '0;
      s1_seg   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ea  <= ea_next;
        s1_seg <= seg_next;
      end
    end
  end

  // Descriptor-cache base lookup; selectors past the cache read as base 0.
  always_comb begin
    sel_base = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if ({29'd0, s1_seg} == 32'(k)) begin
        sel_base = seg_base[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign seg_bad     = ({29'd0, s1_seg} >= 32'(NUM_SEG));
  assign linear_next = sel_base + s1_ea;

`ifdef AGU_LIMIT_CHECK_EN
  logic [ADDR_WIDTH-1:0] sel_limit;

  // Descriptor-cache limit lookup for the inclusive byte-granular check.
  always_comb begin
    sel_limit = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if ({29'd0, s1_seg} == 32'(k)) begin
        sel_limit = seg_limit[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign limit_fault = (s1_ea > sel_limit);
`else
  logic limit_unused;
  assign limit_unused = ^seg_limit;
  assign limit_fault  = 1'b0;
`endif

  // Output stage register: holds steady under backpressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_linear <= '0;
      out_offset <= '0;
      out_seg    <= '0;
      out_fault  <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_linear <= linear_next;
        out_offset <= s1_ea;
        out_seg    <= s1_seg;
        out_fault  <= seg_bad || limit_fault;
      end
    end
  end

endmodule

// File: tb/tb_address_generate_pipe.sv
// Testbench for address_generate_pipe: directed scenarios plus a randomized
// stream checked against an arithmetic reference model and an ordered queue.
`timescale 1ns/1ps
module tb_address_generate_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_address_size;
  logic [31:0] in_base;
  logic [31:0] in_index;
  logic [1:0]  in_scale;
  logic [31:0] in_displacement;
  logic [2:0]  in_seg_default;
  logic        in_seg_override_valid;
  logic [2:0]  in_seg_override;
  logic [191:0] seg_base;
  logic [191:0] seg_limit;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_linear;
  logic [31:0] out_offset;
  logic [2:0]  out_seg;
  logic        out_fault;

  typedef struct packed {
    logic [31:0] linear;
    logic [31:0] offset;
    logic [2:0]  seg;
    logic        fault;
  } res_t;

  typedef struct packed {
    logic        asz;
    logic [31:0] base;
    logic [31:0] index;
    logic [1:0]  scale;
    logic [31:0] disp;
    logic [2:0]  sdef;
    logic        ov;
    logic [2:0]  so;
  } req_t;

  logic [31:0] sb [6];
  logic [31:0] sl [6];
  res_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [31:0] last_linear, last_offset;
  logic [2:0]  last_seg;
  logic        last_fault;

  address_generate_pipe #(.ADDR_WIDTH(32), .NUM_SEG(6)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_address_size(in_address_size), .in_base(in_base), .in_index(in_index),
    .in_scale(in_scale), .in_displacement(in_displacement),
    .in_seg_default(in_seg_default), .in_seg_override_valid(in_seg_override_valid),
    .in_seg_override(in_seg_override), .seg_base(seg_base), .seg_limit(seg_limit),
    .out_valid(out_valid), .out_ready(out_ready), .out_linear(out_linear),
    .out_offset(out_offset), .out_seg(out_seg), .out_fault(out_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    seg_base  = '0;
    seg_limit = '0;
    for (int k = 0; k < 6; k++) begin
      seg_base[k*32 +: 32]  = sb[k];
      seg_limit[k*32 +: 32] = sl[k];
    end
  end

  // Reference: EA from plain arithmetic, then segment base/limit rules.
  function automatic res_t model_cur();
    logic [63:0] sum;
    logic [31:0] ea;
    logic [2:0]  s;
    logic        bad;
    logic [31:0] bv;
    res_t r;
    sum = 64'(in_base) + 64'(in_index) * (64'd1 << in_scale) + 64'(in_displacement);
    ea  = sum[31:0];
    if (!in_address_size) ea = ea % 32'h10000;
    s   = in_seg_override_valid ? in_seg_override : in_seg_default;
    bad = (int'(s) > 5);
    bv  = bad ? 32'd0 : sb[s];
    r.linear = bv + ea;
    r.offset = ea;
    r.seg    = s;
`ifdef AGU_LIMIT_CHECK_EN
    r.fault  = bad || (!bad && (ea > sl[s]));
`else
    r.fault  = bad;
`endif
    return r;
  endfunction

  task automatic set_req(input req_t q);
    in_address_size       = q.asz;
    in_base               = q.base;
    in_index              = q.index;
    in_scale              = q.scale;
    in_displacement       = q.disp;
    in_seg_default        = q.sdef;
    in_seg_override_valid = q.ov;
    in_seg_override       = q.so;
  endtask

  // One clock: sample handshakes just after the falling edge, score the
  // consumed result, record the accepted request, then wait a full cycle.
  task automatic tick(output bit acc);
    res_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got linear=%h offset=%h, no result outstanding", out_linear, out_offset);
      end else begin
        e = exp_q.pop_front();
        if (out_linear !== e.linear || out_offset !== e.offset || out_seg !== e.seg || out_fault !== e.fault) begin
          errors++;
          $display("FAIL sb_result got lin=%h off=%h seg=%0d flt=%b expected lin=%h off=%h seg=%0d flt=%b",
                   out_linear, out_offset, out_seg, out_fault, e.linear, e.offset, e.seg, e.fault);
        end
      end
      last_linear = out_linear;
      last_offset = out_offset;
      last_seg    = out_seg;
      last_fault  = out_fault;
      delivered++;
    end
    if (acc) exp_q.push_back(model_cur());
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < budget && exp_q.size() != 0; n++) tick(acc);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout outstanding=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_one(input req_t q);
    bit acc;
    acc = 1'b0;
    set_req(q);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && !acc; n++) tick(acc);
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout accepted=0 required=1");
    end
    drain(20);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_req('0);
    for (int k = 0; k < 6; k++) begin sb[k] = 32'd0; sl[k] = 32'hFFFF_FFFF; end
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_linear !== 32'd0 || out_offset !== 32'd0 || out_seg !== 3'd0 || out_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b lin=%h off=%h seg=%0d flt=%b required all zero",
               out_valid, out_linear, out_offset, out_seg, out_fault);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    @(negedge clock);
  endtask

  task automatic test_basic();
    bit acc;
    sb[3] = 32'h20000;
    out_ready = 1'b1;
    set_req('{asz:1'b1, base:32'h1000, index:32'h10, scale:2'd2, disp:32'h8, sdef:3'd3, ov:1'b0, so:3'd0});
    in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency1 out_valid got %b required 0", out_valid);
    end
    tick(acc);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_linear !== 32'h21048 || out_offset !== 32'h1048 || out_seg !== 3'd3 || out_fault !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got v=%b lin=%h off=%h seg=%0d flt=%b required v=1 lin=00021048 off=00001048 seg=3 flt=0",
               out_valid, out_linear, out_offset, out_seg, out_fault);
    end
    drain(20);
  endtask

  task automatic test_wrap16();
    sb[2] = 32'h100;
    run_one('{asz:1'b0, base:32'hFFF0, index:32'h0, scale:2'd0, disp:32'h20, sdef:3'd2, ov:1'b0, so:3'd0});
    checks++;
    if (last_offset !== 32'h10 || last_linear !== 32'h110) begin
      errors++;
      $display("FAIL wrap16 got off=%h lin=%h required off=00000010 lin=00000110", last_offset, last_linear);
    end
  endtask

  task automatic test_override();
    sb[0] = 32'h5000;
    run_one('{asz:1'b1, base:32'h4, index:32'h0, scale:2'd0, disp:32'h0, sdef:3'd3, ov:1'b1, so:3'd0});
    checks++;
    if (last_seg !== 3'd0 || last_linear !== 32'h5004 || last_fault !== 1'b0) begin
      errors++;
      $display("FAIL override_es got seg=%0d lin=%h flt=%b required seg=0 lin=00005004 flt=0", last_seg, last_linear, last_fault);
    end
    run_one('{asz:1'b1, base:32'h4, index:32'h0, scale:2'd0, disp:32'h0, sdef:3'd3, ov:1'b1, so:3'd7});
    checks++;
    if (last_seg !== 3'd7 || last_fault !== 1'b1) begin
      errors++;
      $display("FAIL override_bad got seg=%0d flt=%b required seg=7 flt=1", last_seg, last_fault);
    end
  endtask

  task automatic test_back_to_back();
    req_t r [4];
    int n;
    int d0;
    bit acc;
    logic [31:0] held;
    sb[3] = 32'h20000;
    for (int k = 0; k < 4; k++)
      r[k] = '{asz:1'b1, base:32'h100 * (k + 1), index:32'h0, scale:2'd0, disp:32'h0, sdef:3'd3, ov:1'b0, so:3'd0};
    n = 0;
    d0 = delivered;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(r[n]);
      in_valid = 1'b1;
      tick(acc);
      if (acc) n++;
    end
    #1;
    checks++;
    if (n !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_linear !== 32'h20100) begin
      errors++;
      $display("FAIL bp_stall got accepts=%0d in_ready=%b v=%b lin=%h required accepts=2 in_ready=0 v=1 lin=00020100",
               n, in_ready, out_valid, out_linear);
    end
    held = out_linear;
    tick(acc);
    if (acc) n++;
    tick(acc);
    if (acc) n++;
    #1;
    checks++;
    if (out_linear !== held || n !== 2) begin
      errors++;
      $display("FAIL bp_hold got lin=%h accepts=%0d required lin=%h accepts=2", out_linear, n, held);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      set_req(r[n]);
      in_valid = 1'b1;
      tick(acc);
      if (acc) n++;
    end
    drain(20);
    checks++;
    if (delivered - d0 !== 4 || last_linear !== 32'h20400) begin
      errors++;
      $display("FAIL bp_delivered got count=%0d last=%h required count=4 last=00020400", delivered - d0, last_linear);
    end
  endtask

  task automatic test_limit();
    logic exp_f;
`ifdef AGU_LIMIT_CHECK_EN
    exp_f = 1'b1;
`else
    exp_f = 1'b0;
`endif
    sb[3] = 32'h0;
    sl[3] = 32'hFFFF;
    run_one('{asz:1'b1, base:32'h10000, index:32'h0, scale:2'd0, disp:32'h0, sdef:3'd3, ov:1'b0, so:3'd0});
    checks++;
    if (last_fault !== exp_f || last_linear !== 32'h10000) begin
      errors++;
      $display("FAIL limit_over got flt=%b lin=%h required flt=%b lin=00010000", last_fault, last_linear, exp_f);
    end
    run_one('{asz:1'b1, base:32'hFFFF, index:32'h0, scale:2'd0, disp:32'h0, sdef:3'd3, ov:1'b0, so:3'd0});
    checks++;
    if (last_fault !== 1'b0) begin
      errors++;
      $display("FAIL limit_edge got flt=%b required 0", last_fault);
    end
    sl[3] = 32'hFFFF_FFFF;
  endtask

  task automatic test_random();
    bit acc;
    bit pending;
    req_t q;
    for (int k = 0; k < 6; k++) begin
      sb[k] = $urandom;
      sl[k] = $urandom;
    end
    pending = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending) begin
        q.asz   = 1'($urandom_range(0, 1));
        q.base  = $urandom;
        q.index = $urandom;
        q.scale = 2'($urandom_range(0, 3));
        q.disp  = $urandom;
        q.sdef  = 3'($urandom_range(0, 7));
        q.ov    = 1'($urandom_range(0, 1));
        q.so    = 3'($urandom_range(0, 7));
        set_req(q);
        pending = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
      if (acc) pending = 1'b0;
    end
    drain(40);
  endtask

  task automatic test_reset_midflight();
    bit acc;
    sb[3] = 32'h20000;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_req('{asz:1'b1, base:32'h11, index:32'h0, scale:2'd0, disp:32'h0, sdef:3'd3, ov:1'b0, so:3'd0});
    tick(acc);
    set_req('{asz:1'b1, base:32'h22, index:32'h0, scale:2'd0, disp:32'h0, sdef:3'd3, ov:1'b0, so:3'd0});
    tick(acc);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_linear !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async got v=%b lin=%h required v=0 lin=00000000", out_valid, out_linear);
    end
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(acc);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale cycle=%0d out_valid got %b required 0", c, out_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap16();
    test_override();
    test_back_to_back();
    test_limit();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
